wb_stage: RTL
=============

# wb_stage

Writeback stage of the KNIPS pipeline, directly upstream of the register file's write port. Accepts completed instructions from execute over a valid/ready handshake and, for loads, waits for the data-memory response. Drives the register file's `write_en`/`waddr`/`data_in` from registers. Optionally forwards the in-flight write to the operand read path, which covers the same-cycle write/read case that the register file itself cannot see.

## Interface
Parameters:
- `W`, 8, data width.
- `D`, 4, register address width (2**D registers).
- `TIMEOUT`, 15, maximum cycles spent in `WAIT_MEM` before a load is abandoned. Range 1..255.

Ports:
- `CLK` in 1: the single clock; everything is sampled on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `ex_valid` in 1: execute presents an instruction.
- `ex_ready` out 1: this stage can accept an instruction.
- `ex_is_load` in 1: 1 = result comes from memory; 0 = result is `ex_result`.
- `ex_dest` in D: destination register.
- `ex_result` in W: ALU result, used only when `ex_is_load`=0.
- `mem_rvalid` in 1: load data valid.
- `mem_rdata` in W: load data.
- `write_en` out 1: register file write strobe.
- `waddr` out D: register file write address.
- `data_in` out W: register file write data.
- `rdA_addr`, `rdB_addr` in D: operand addresses, the same values as the register file's `raddrA`/`raddrB`.
- `rfA_data`, `rfB_data` in W: register file `data_outA`/`data_outB`.
- `opA`, `opB` out W: operands after forwarding.
- `retired_cnt` out 16: retired-instruction count.
- `err` out 1: sticky error flag.

## Operation
- **Handshake:** a transfer occurs on a cycle with `ex_valid`=1 and `ex_ready`=1. `ex_ready` = (state==`IDLE`) && !`RESET`, combinational.
- **States:** `IDLE` and `WAIT_MEM`, plus an internal timeout counter `tcnt` of 8 bits.
- **ALU transfer in `IDLE`:**
  - Register `waddr`=`ex_dest` and `data_in`=`ex_result`.
  - Register `write_en`=(`ex_dest`!=0).
  - Stay in `IDLE`.
- **Load transfer in `IDLE`:**
  - Latch `ex_dest`, set `tcnt`=0, go to `WAIT_MEM`.
  - `write_en` is 0 next cycle.
- **In `WAIT_MEM`, when `mem_rvalid`=1:**
  - Register `waddr`=latched dest and `data_in`=`mem_rdata`.
  - Register `write_en`=(dest!=0).
  - Go to `IDLE`.
- **In `WAIT_MEM`, when `mem_rvalid`=0:**
  - `tcnt` increments.
  - When `tcnt` reaches `TIMEOUT`, with no valid data that cycle: go to `IDLE`, set `err`=1, no write, do not count as retired.
- **Stray response:** `mem_rvalid`=1 while in `IDLE` sets `err`=1, and the data is discarded. This includes the cycle in which a load is accepted, because a response must arrive at least one cycle after acceptance.
- **Write pulse:** `write_en` is a one-cycle pulse. It deasserts on the following cycle unless a new write is produced that cycle.
- **Retire count:** `retired_cnt` increments by 1 the cycle after each completed instruction (ALU write or load write), including writes to dest 0. It wraps 0xFFFF -> 0.
- **Error clear:** `err` clears only on `RESET`.
- **Forwarding** (see Configuration):
  - `opA` = `data_in` if `write_en`=1 && `waddr`==`rdA_addr` && `rdA_addr`!=0; otherwise `rfA_data`.
  - `opB` is formed the same way.

## Timing
- Reset values: `write_en`=0, `waddr`=0, `data_in`=0, `retired_cnt`=0, `err`=0, state=`IDLE`, `tcnt`=0. `ex_ready`=0 while `RESET`=1.
- ALU latency: the transfer happens in cycle N; `write_en` is high in cycle N+1; the register file updates at the end of N+1. Back-to-back ALU transfers sustain one per cycle.
- Load latency: accepted in cycle N, `mem_rvalid` in cycle M>N, `write_en` in M+1, `ex_ready` high again in M+1.
- Maximum `WAIT_MEM` dwell is `TIMEOUT`+1 cycles.
- Reset mid-`WAIT_MEM` drops the pending load. No write occurs and `err` is unchanged except that it is cleared by the reset.
- `opA`/`opB` are purely combinational from the current-cycle inputs and registers.

## Configuration
- Macro: `WB_BYPASS_EN`.
- Defined: forwarding as specified above.
- Undefined: `opA`=`rfA_data` and `opB`=`rfB_data` directly, with no comparators. Execute must then stall one cycle on a same-cycle read-after-write.

## Test plan
- **Reset and ALU writes:** hold `RESET` 2 cycles; check every output is at its reset value. Then send ALU dest=3, result=0x5A, and the next cycle ALU dest=4, result=0x11 -> `write_en`=1 with (3,0x5A) then (4,0x11) on consecutive cycles, and `retired_cnt`=2.
- **Load:** load dest=7, `mem_rvalid` 3 cycles later with 0xC3 -> `ex_ready`=0 for exactly 3 cycles, then `write_en`=1 with (7,0xC3) the cycle after `rvalid`.
- **Timeout:** load with no response -> state returns to `IDLE` after `TIMEOUT`+1 cycles, `err`=1, no write, `retired_cnt` unchanged.
- **Dest 0:** ALU dest=0, result=0xFF -> `write_en` stays 0, `retired_cnt` increments, `opA`=`rfA_data` for `rdA_addr`=0.
- **Forwarding and counter wrap:**
  - `write_en`=1 with (5,0x22), `rdA_addr`=5, `rfA_data`=0x00 -> `opA`=0x22 with `WB_BYPASS_EN` defined, 0x00 without.
  - 65536 ALU retires -> `retired_cnt` wraps to 0.
- **Stray response and reset mid-load:** `mem_rvalid` in `IDLE` -> `err`=1 and no write. `RESET` during `WAIT_MEM` -> `IDLE`, `err`=0, and no write the following cycle.

Source files
------------

// File: rtl/wb_stage_if.sv
// Bundle between execute, data memory, register file and the KNIPS writeback stage.
// The slave modport is the writeback stage; the master modport is everything around it.
interface wb_stage_if #(
    parameter int W = 8,
    parameter int D = 4
);
    logic         ex_valid;
    logic         ex_ready;
    logic         ex_is_load;
    logic [D-1:0] ex_dest;
    logic [W-1:0] ex_result;
    logic         mem_rvalid;
    logic [W-1:0] mem_rdata;
    logic         write_en;
    logic [D-1:0] waddr;
    logic [W-1:0] data_in;
    logic [D-1:0] rdA_addr;
    logic [D-1:0] rdB_addr;
    logic [W-1:0] rfA_data;
    logic [W-1:0] rfB_data;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic [15:0]  retired_cnt;
    logic         err;

    modport slave (
        input  ex_valid, ex_is_load, ex_dest, ex_result,
        input  mem_rvalid, mem_rdata,
        input  rdA_addr, rdB_addr, rfA_data, rfB_data,
        output ex_ready, write_en, waddr, data_in,
        output opA, opB, retired_cnt, err
    );

    modport master (
        output ex_valid, ex_is_load, ex_dest, ex_result,
        output mem_rvalid, mem_rdata,
        output rdA_addr, rdB_addr, rfA_data, rfB_data,
        input  ex_ready, write_en, waddr, data_in,
        input  opA, opB, retired_cnt, err
    );
endinterface

// File: rtl/wb_stage.sv
// KNIPS writeback stage: registers ALU/load results onto the register-file write port.
// Define WB_BYPASS_EN to forward the in-flight write onto the operand read path.
module wb_stage #(
    parameter int W       = 8,
    parameter int D       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    wb_stage_if.slave   bus
);
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    localparam logic [7:0] TMO = TIMEOUT[7:0];

    state_t       state_q, state_d;
    logic [7:0]   tcnt_q, tcnt_d;
    logic [D-1:0] dest_q, dest_d;
    logic         we_q, we_d;
    logic [D-1:0] waddr_q, waddr_d;
    logic [W-1:0] data_q, data_d;
    logic [15:0]  retired_q, retired_d;
    logic         err_q, err_d;
    logic         ready;
    logic         accept;
    logic         retire;

    assign ready  = (state_q == IDLE) && !RESET;
    assign accept = bus.ex_valid && ready;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        dest_d  = dest_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        data_d  = data_q;
        err_d   = err_q;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                // Any response here is unsolicited, including on the cycle a load is accepted.
                if (bus.mem_rvalid) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    if (bus.ex_is_load) begin
                        dest_d  = bus.ex_dest;
                        tcnt_d  = 8'd0;
                        state_d = WAIT_MEM;
                    end else begin
                        waddr_d = bus.ex_dest;
                        data_d  = bus.ex_result;
                        we_d    = (bus.ex_dest != '0);
                        retire  = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    waddr_d = dest_q;
                    data_d  = bus.mem_rdata;
                    we_d    = (dest_q != '0);
                    retire  = 1'b1;
                    state_d = IDLE;
                end else if (tcnt_q == TMO) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d  = tcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        retired_d = retire ? retired_q + 16'd1 : retired_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            tcnt_q    <= 8'd0;
            dest_q    <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            data_q    <= '0;
            retired_q <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            dest_q    <= dest_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            data_q    <= data_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    assign bus.ex_ready    = ready;
    assign bus.write_en    = we_q;
    assign bus.waddr       = waddr_q;
    assign bus.data_in     = data_q;
    assign bus.retired_cnt = retired_q;
    assign bus.err         = err_q;

`ifdef WB_BYPASS_EN
    // Register 0 is hardwired, so a pending write to it must never be forwarded.
    logic hit_a;
    logic hit_b;
    assign hit_a   = we_q && (waddr_q == bus.rdA_addr) && (bus.rdA_addr != '0);
    assign hit_b   = we_q && (waddr_q == bus.rdB_addr) && (bus.rdB_addr != '0);
    assign bus.opA = hit_a ? data_q : bus.rfA_data;
    assign bus.opB = hit_b ? data_q : bus.rfB_data;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{bus.rdA_addr, bus.rdB_addr};
    assign bus.opA = bus.rfA_data;
    assign bus.opB = bus.rfB_data;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (!RESET && we_q) begin
            assert (waddr_q != '0)
                else $error("write strobe raised for register 0");
        end
    end
`endif
endmodule
